// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fsub1.sv
`default_nettype none
// ============================================================================
// Module      : fsub1
// Description : Combinational 1-bit full subtractor (D = X - Y - Bin).
// Revision    : 1.0 - initial release
// ============================================================================
module fsub1 (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule
`default_nettype wire

// File: rtl/serial_fsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_fsub
// Description : Bit-serial subtractor, diff = x - y - bin, LSB first over
//               WIDTH cycles with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fsub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_x_sr;
    logic [WIDTH-1:0] r_y_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic             w_last;

    fsub1 u_cell (
        .X    (r_x_sr[0]),
        .Y    (r_y_sr[0]),
        .Bin  (r_borrow),
        .D    (w_d),
        .Bout (w_bo)
    );

    // A start is honoured in IDLE and also in DONE for back-to-back operation.
    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_sr   <= '0;
            r_y_sr   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_x_sr   <= x;
            r_y_sr   <= y;
            r_borrow <= bin;
            r_res    <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_x_sr   <= r_x_sr >> 1;
            r_y_sr   <= r_y_sr >> 1;
            r_res    <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bo;
            r_cnt    <= r_cnt + CW'(1);
            // Outputs only move when the final bit lands, so no partial result leaks.
            if (w_last) begin
                r_diff <= {w_d, r_res[WIDTH-1:1]};
                r_bout <= w_bo;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_fsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_fsub
// Description : Scoreboard bench for serial_fsub (WIDTH=8 and WIDTH=3) and fsub1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_fsub;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, bin = 1'b0;
    logic [7:0] x = '0, y = '0, diff;
    logic       busy, done, bout;

    logic       start3 = 1'b0, bin3 = 1'b0;
    logic [2:0] x3 = '0, y3 = '0, diff3;
    logic       busy3, done3, bout3;

    logic       fx = 1'b0, fy = 1'b0, fb = 1'b0, fd, fbo;

    int   errors = 0;
    int   checks = 0;
    res_t q8[$];
    res_t q3[$];
    res_t last8 = '0;

    always #5 clk = ~clk;

    serial_fsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_fsub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .x(x3), .y(y3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    fsub1 dut1 (.X(fx), .Y(fy), .Bin(fb), .D(fd), .Bout(fbo));

    function automatic res_t model(input int w, input int a, input int b, input int c);
        res_t r;
        int   v;
        v    = (a - b - c) & ((1 << w) - 1);
        r.d  = v[7:0];
        r.bo = (a < b + c);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop on done, and verify diff/bout stay frozen otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last8 = '0;
        end else if (done) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                last8 = q8.pop_front();
                check("w8_diff", {24'd0, diff}, {24'd0, last8.d});
                check("w8_bout", {31'd0, bout}, {31'd0, last8.bo});
            end
        end else begin
            check("w8_hold", {23'd0, diff, bout}, {23'd0, last8.d, last8.bo});
        end
    end

    always @(negedge clk) begin
        if (rst_n && done3) begin
            if (q3.size() == 0) begin
                check("w3_unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = q3.pop_front();
                check("w3_diff", {29'd0, diff3}, {29'd0, e.d[2:0]});
                check("w3_bout", {31'd0, bout3}, {31'd0, e.bo});
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("w8_issue_timeout", 32'd1, 32'd0);
        x = a; y = b; bin = c; start = 1'b1;
        q8.push_back(model(8, int'(a), int'(b), int'(c)));
        @(negedge clk);
        start = 1'b0;
        x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
    endtask

    task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (busy3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy3) check("w3_issue_timeout", 32'd1, 32'd0);
        x3 = a; y3 = b; bin3 = c; start3 = 1'b1;
        q3.push_back(model(3, int'(a), int'(b), int'(c)));
        @(negedge clk);
        start3 = 1'b0;
        x3 = 3'($urandom); y3 = 3'($urandom); bin3 = 1'($urandom);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q3.size() != 0) begin
            check(nm, 32'd1, 32'd0);
            q8.delete();
            q3.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        // fsub1 truth table against plain arithmetic.
        for (int i = 0; i < 8; i++) begin
            fx = i[2]; fy = i[1]; fb = i[0];
            #1;
            check("fsub1_d", {31'd0, fd}, 32'((int'(fx) - int'(fy) - int'(fb)) & 1));
            check("fsub1_bout", {31'd0, fbo}, {31'd0, (int'(fx) < int'(fy) + int'(fb))});
        end

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: busy for 8 cycles after the accepting edge, then one done cycle.
        x = 8'h05; y = 8'h03; bin = 1'b0; start = 1'b1;
        q8.push_back(model(8, 5, 3, 0));
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("lat_busy", {31'd0, busy}, 32'd1);
            check("lat_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("lat_done_pulse", {31'd0, done}, 32'd1);
        check("lat_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue8(8'h00, 8'h01, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1);
        issue8(8'hA5, 8'h5A, 1'b0);
        drain("dir_timeout");

        // Start during RUN is ignored; then back-to-back start in DONE.
        issue8(8'h3C, 8'h11, 1'b1);
        repeat (2) @(negedge clk);
        x = 8'hEE; y = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done", {31'd0, done}, 32'd1);
        end
        x = 8'h10; y = 8'h20; bin = 1'b1; start = 1'b1;
        q8.push_back(model(8, 16, 32, 1));
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("b2b_not_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("b2b_second_done", {31'd0, done}, 32'd1);
        drain("b2b_timeout");

        // Async reset mid-RUN aborts with no done pulse.
        issue8(8'h77, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_bout", {31'd0, bout}, 32'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue8(8'h09, 8'h04, 1'b1);
        drain("post_rst_timeout");

        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain("rand_timeout");

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    issue3(a[2:0], b[2:0], c[0]);
        drain("w3_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
